seq_mem_nport: RTL and testbench
================================

SEQ_MEM_NPORT -- requirements
Module: seq_mem_nport

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter SIZE, default 16, number of words; SHALL satisfy 1 <= SIZE <= 2**IDX_SIZE.
REQ-003 Parameter IDX_SIZE, default 4, address width in bits.
REQ-004 Parameter NPORTS, default 4, number of independent request ports; SHALL be 1..16.
REQ-005 Parameter LATENCY, default 5, request-to-response delay in cycles; SHALL be 1..8.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 port_en  input  NPORTS  per-port request strobe; port i uses bit i.
REQ-009 port_we  input  NPORTS  per-port write select (1 = write, 0 = read); qualified by port_en.
REQ-010 port_addr  input  NPORTS*IDX_SIZE  word address; port i at bits [i*IDX_SIZE +: IDX_SIZE].
REQ-011 port_wdata  input  NPORTS*WIDTH  write data; port i at [i*WIDTH +: WIDTH].
REQ-012 port_wstrb  input  NPORTS*(WIDTH/8)  byte write enables; port i at [i*WIDTH/8 +: WIDTH/8].
REQ-013 port_done  output  NPORTS  one-cycle response pulse per accepted request.
REQ-014 port_rdata  output  NPORTS*WIDTH  read response data, valid when matching port_done bit is 1.
REQ-015 port_err  output  NPORTS  out-of-bounds flag, valid when matching port_done bit is 1.
REQ-016 port_conflict  output  NPORTS  write-lost flag, valid when matching port_done bit is 1.

Function
REQ-017 A request on port i SHALL be accepted at every rising edge where port_en[i]=1 and reset=0; no backpressure, one request per port per cycle.
REQ-018 port_done[i] SHALL pulse high for exactly one cycle, LATENCY cycles after the request cycle (LATENCY=1: cycle immediately after acceptance edge).
REQ-019 Responses SHALL leave each port in acceptance order, fully pipelined; back-to-back requests give back-to-back done pulses.
REQ-020 Memory SHALL be sampled and written at the acceptance edge; response pipeline carries results only.
REQ-021 Reads SHALL return pre-edge contents: read and write to same address at same edge return old data.
REQ-022 A write SHALL update only bytes whose wstrb bit is 1; wstrb all-zero SHALL leave the word unchanged but still produce done.
REQ-023 Multiple writes to one address at one edge: lowest-indexed port SHALL win per byte it enables; bytes it does not enable go to next-lowest enabling port.
REQ-024 A writing port with no bytes committed because lower ports wrote all its enabled bytes SHALL report port_conflict=1; otherwise port_conflict=0.
REQ-025 port_rdata SHALL be all-zero for write responses and whenever port_done bit is 0.
REQ-026 Address >= SIZE SHALL give port_err=1, rdata all-zero, no memory change; not a conflict.
REQ-027 port_err and port_conflict SHALL be 0 whenever the matching port_done bit is 0.
REQ-028 port_we, port_addr, port_wdata, port_wstrb SHALL be ignored when port_en bit is 0.

Reset
REQ-029 While reset=1, port_done, port_err, port_conflict, port_rdata SHALL be all-zero, asynchronously.
REQ-030 Reset SHALL clear all in-flight responses; requests accepted before reset SHALL never produce done.
REQ-031 Requests presented while reset=1 SHALL be ignored, with no memory write.
REQ-032 Memory contents SHALL NOT be cleared by reset and SHALL persist across reset.
REQ-033 First request after reset deassertion SHALL be accepted at the first rising edge with reset=0.

Verification
REQ-034 WIDTH=32, LATENCY=5: port0 write addr 3 data 0xDEADBEEF wstrb 0xF; next cycle port1 read addr 3 -> port1_done pulses 5 cycles later, rdata 0xDEADBEEF, err 0.
REQ-035 Same edge: port0 write addr 2 wstrb 0x3 data 0x0000AAAA; port2 write addr 2 wstrb 0xF data 0x11111111 (old 0) -> word 0x1111AAAA, both conflict 0; repeat with port2 wstrb 0x3 -> port2 conflict 1.
REQ-036 Same edge: port1 write addr 5 data 0x5; port3 read addr 5 (old 0x9) -> port3 rdata 0x9; read next cycle returns 0x5.
REQ-037 SIZE=12, IDX_SIZE=4: read addr 13 -> done with err 1, rdata 0; write addr 13 -> err 1, no word modified.
REQ-038 Requests on all ports 3 cycles running, reset asserted 2 cycles after last -> no done pulses during or after reset; pre-reset written data still readable afterwards.
REQ-039 LATENCY=1, NPORTS=8: every port reads every cycle for 20 cycles -> done high on every port each cycle from cycle 1, data in request order.

Source files
------------

// File: rtl/seq_mem_nport.sv
// Multi-port word memory with byte strobes and a fixed-latency response pipeline.
// Same-edge writes resolve per byte in favour of the lowest-indexed port.
module seq_mem_nport #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4,
    parameter int NPORTS   = 4,
    parameter int LATENCY  = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NPORTS-1:0]             port_en,
    input  logic [NPORTS-1:0]             port_we,
    input  logic [NPORTS*IDX_SIZE-1:0]    port_addr,
    input  logic [NPORTS*WIDTH-1:0]       port_wdata,
    input  logic [NPORTS*(WIDTH/8)-1:0]   port_wstrb,
    output logic [NPORTS-1:0]             port_done,
    output logic [NPORTS*WIDTH-1:0]       port_rdata,
    output logic [NPORTS-1:0]             port_err,
    output logic [NPORTS-1:0]             port_conflict
);

    localparam int NB = WIDTH / 8;
    localparam logic [IDX_SIZE:0] LP_SIZE = (IDX_SIZE + 1)'(SIZE);

    logic [WIDTH-1:0] r_mem [SIZE];

    logic [NPORTS-1:0][IDX_SIZE-1:0] w_addr;
    logic [NPORTS-1:0]               w_inBounds;
    logic [NPORTS-1:0]               w_write;
    logic [NPORTS-1:0]               w_read;
    logic [NPORTS-1:0][NB-1:0]       w_commit;
    logic [NPORTS-1:0]               w_conflict;
    logic [NPORTS*WIDTH-1:0]         w_rdata;

    logic [LATENCY-1:0][NPORTS-1:0]       r_pipeDone;
    logic [LATENCY-1:0][NPORTS-1:0]       r_pipeErr;
    logic [LATENCY-1:0][NPORTS-1:0]       r_pipeConf;
    logic [LATENCY-1:0][NPORTS*WIDTH-1:0] r_pipeData;

    // A byte commits only if no lower-indexed port writes the same byte of the same word.
    always_comb begin
        w_addr     = '0;
        w_inBounds = '0;
        w_write    = '0;
        w_read     = '0;
        w_commit   = '0;
        w_conflict = '0;
        w_rdata    = '0;
        for (int i = 0; i < NPORTS; i++) begin
            w_addr[i]     = port_addr[i*IDX_SIZE +: IDX_SIZE];
            w_inBounds[i] = ({1'b0, w_addr[i]} < LP_SIZE);
            w_write[i]    = ~reset & port_en[i] & port_we[i] & w_inBounds[i];
            w_read[i]     = port_en[i] & ~port_we[i] & w_inBounds[i];
        end
        for (int i = 0; i < NPORTS; i++) begin
            for (int b = 0; b < NB; b++) begin
                w_commit[i][b] = w_write[i] & port_wstrb[i*NB + b];
                for (int j = 0; j < i; j++) begin
                    if (w_write[j] && (w_addr[j] == w_addr[i]) && port_wstrb[j*NB + b]) begin
                        w_commit[i][b] = 1'b0;
                    end
                end
            end
            w_conflict[i] = w_write[i] & (|port_wstrb[i*NB +: NB]) & ~(|w_commit[i]);
            if (w_read[i]) begin
                w_rdata[i*WIDTH +: WIDTH] = r_mem[w_addr[i]];
            end
        end
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++) begin
            for (int b = 0; b < NB; b++) begin
                if (w_commit[i][b]) begin
                    r_mem[w_addr[i]][b*8 +: 8] <= port_wdata[i*WIDTH + b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipeDone <= '0;
            r_pipeErr  <= '0;
            r_pipeConf <= '0;
            r_pipeData <= '0;
        end else begin
            r_pipeDone[0] <= port_en;
            r_pipeErr[0]  <= port_en & ~w_inBounds;
            r_pipeConf[0] <= w_conflict;
            r_pipeData[0] <= w_rdata;
            for (int s = 1; s < LATENCY; s++) begin
                r_pipeDone[s] <= r_pipeDone[s-1];
                r_pipeErr[s]  <= r_pipeErr[s-1];
                r_pipeConf[s] <= r_pipeConf[s-1];
                r_pipeData[s] <= r_pipeData[s-1];
            end
        end
    end

    assign port_done     = r_pipeDone[LATENCY-1];
    assign port_err      = r_pipeErr[LATENCY-1];
    assign port_conflict = r_pipeConf[LATENCY-1];
    assign port_rdata    = r_pipeData[LATENCY-1];

endmodule

// File: tb/tb_seq_mem_nport.sv
// Scoreboard bench for seq_mem_nport: a 4-port LATENCY=5 SIZE=12 instance and
// an 8-port LATENCY=1 instance, each with per-port expected-response queues.
module tb_seq_mem_nport;

    localparam int NP   = 4;
    localparam int LAT  = 5;
    localparam int FNP  = 8;
    localparam int FLAT = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NP-1:0]      en, we, done, err, conf;
    logic [NP*4-1:0]    addr, wstrb;
    logic [NP*32-1:0]   wdata, rdata;

    logic [FNP-1:0]     fEn, fWe, fDone, fErr, fConf;
    logic [FNP*4-1:0]   fAddr, fWstrb;
    logic [FNP*32-1:0]  fWdata, fRdata;

    int cyc = 0;
    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        conf;
        int          cyc;
    } exp_t;

    exp_t expQ[NP][$];
    exp_t fExpQ[FNP][$];

    seq_mem_nport #(.WIDTH(32), .SIZE(12), .IDX_SIZE(4), .NPORTS(NP), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .port_en(en), .port_we(we), .port_addr(addr), .port_wdata(wdata), .port_wstrb(wstrb),
        .port_done(done), .port_rdata(rdata), .port_err(err), .port_conflict(conf)
    );

    seq_mem_nport #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4), .NPORTS(FNP), .LATENCY(FLAT)) u_fast (
        .clk(clk), .reset(reset),
        .port_en(fEn), .port_we(fWe), .port_addr(fAddr), .port_wdata(fWdata), .port_wstrb(fWstrb),
        .port_done(fDone), .port_rdata(fRdata), .port_err(fErr), .port_conflict(fConf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumers: every done pops and checks, every idle port must be all-zero.
    always @(negedge clk) begin
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            testsRun++;
            if (done[p] === 1'b1) begin
                if (expQ[p].size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL main_unexpected_done port %0d cycle %0d got done=1 want 0", p, cyc);
                end else begin
                    e = expQ[p].pop_front();
                    if ({rdata[p*32 +: 32], err[p], conf[p]} !== {e.data, e.err, e.conf} || cyc != e.cyc) begin
                        testsFailed++;
                        $display("[TB] FAIL main_resp port %0d got data=%h err=%b conf=%b cyc=%0d want data=%h err=%b conf=%b cyc=%0d",
                                 p, rdata[p*32 +: 32], err[p], conf[p], cyc, e.data, e.err, e.conf, e.cyc);
                    end
                end
            end else if ({done[p], rdata[p*32 +: 32], err[p], conf[p]} !== '0) begin
                testsFailed++;
                $display("[TB] FAIL main_idle port %0d cycle %0d got done=%b data=%h err=%b conf=%b want all zero",
                         p, cyc, done[p], rdata[p*32 +: 32], err[p], conf[p]);
            end
        end
        for (int p = 0; p < FNP; p++) begin
            testsRun++;
            if (fDone[p] === 1'b1) begin
                if (fExpQ[p].size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL fast_unexpected_done port %0d cycle %0d got done=1 want 0", p, cyc);
                end else begin
                    e = fExpQ[p].pop_front();
                    if ({fRdata[p*32 +: 32], fErr[p], fConf[p]} !== {e.data, e.err, e.conf} || cyc != e.cyc) begin
                        testsFailed++;
                        $display("[TB] FAIL fast_resp port %0d got data=%h err=%b conf=%b cyc=%0d want data=%h err=%b conf=%b cyc=%0d",
                                 p, fRdata[p*32 +: 32], fErr[p], fConf[p], cyc, e.data, e.err, e.conf, e.cyc);
                    end
                end
            end else if ({fDone[p], fRdata[p*32 +: 32], fErr[p], fConf[p]} !== '0) begin
                testsFailed++;
                $display("[TB] FAIL fast_idle port %0d cycle %0d got done=%b data=%h err=%b conf=%b want all zero",
                         p, cyc, fDone[p], fRdata[p*32 +: 32], fErr[p], fConf[p]);
            end
        end
    end

    task automatic setMain(input int p, input logic w, input logic [3:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        en[p] = 1'b1;
        we[p] = w;
        addr[p*4 +: 4] = a;
        wdata[p*32 +: 32] = d;
        wstrb[p*4 +: 4] = s;
    endtask

    task automatic req(input int p, input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] ed, input logic ee, input logic ec);
        exp_t e;
        setMain(p, w, a, d, s);
        e.data = ed;
        e.err  = ee;
        e.conf = ec;
        e.cyc  = cyc + LAT;
        expQ[p].push_back(e);
    endtask

    task automatic fReq(input int p, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [31:0] ed);
        exp_t e;
        fEn[p] = 1'b1;
        fWe[p] = w;
        fAddr[p*4 +: 4] = a;
        fWdata[p*32 +: 32] = d;
        fWstrb[p*4 +: 4] = 4'hF;
        e.data = ed;
        e.err  = 1'b0;
        e.conf = 1'b0;
        e.cyc  = cyc + FLAT;
        fExpQ[p].push_back(e);
    endtask

    task automatic clearInputs();
        en = '0; we = '0; addr = '0; wdata = '0; wstrb = '0;
        fEn = '0; fWe = '0; fAddr = '0; fWdata = '0; fWstrb = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        clearInputs();
    endtask

    task automatic waitIdle(input int budget);
        int  n = 0;
        bit  busy;
        do begin
            busy = 1'b0;
            for (int p = 0; p < NP; p++) if (expQ[p].size() != 0) busy = 1'b1;
            for (int p = 0; p < FNP; p++) if (fExpQ[p].size() != 0) busy = 1'b1;
            if (busy) begin
                @(negedge clk);
                n++;
            end
        end while (busy && n < budget);
        for (int p = 0; p < NP; p++) begin
            testsRun++;
            if (expQ[p].size() != 0) begin
                testsFailed++;
                $display("[TB] FAIL main_timeout port %0d got %0d pending want 0", p, expQ[p].size());
                expQ[p].delete();
            end
        end
        for (int p = 0; p < FNP; p++) begin
            testsRun++;
            if (fExpQ[p].size() != 0) begin
                testsFailed++;
                $display("[TB] FAIL fast_timeout port %0d got %0d pending want 0", p, fExpQ[p].size());
                fExpQ[p].delete();
            end
        end
    endtask

    function automatic logic [31:0] pat(input int a);
        return 32'hF00D0000 | 32'(a * 17);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        clearInputs();
        #1;
        testsRun++;
        if ({done, rdata, err, conf} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_main got done=%b err=%b conf=%b want all zero", done, err, conf);
        end
        testsRun++;
        if ({fDone, fRdata, fErr, fConf} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_fast got done=%b err=%b conf=%b want all zero", fDone, fErr, fConf);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_init();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < NP; p++) req(p, 1'b1, 4'(k*4 + p), 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
            tick();
        end
        waitIdle(20);
    endtask

    task automatic test_write_read();
        req(0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0);
        tick();
        req(1, 1'b0, 4'd3, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        waitIdle(20);
    endtask

    task automatic test_byte_merge();
        req(0, 1'b1, 4'd2, 32'h0000AAAA, 4'h3, 32'h0, 1'b0, 1'b0);
        req(2, 1'b1, 4'd2, 32'h11111111, 4'hF, 32'h0, 1'b0, 1'b0);
        tick();
        req(0, 1'b0, 4'd2, 32'h0, 4'h0, 32'h1111AAAA, 1'b0, 1'b0);
        tick();
        req(0, 1'b1, 4'd2, 32'h0000BBBB, 4'h3, 32'h0, 1'b0, 1'b0);
        req(1, 1'b1, 4'd2, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1'b0);
        req(2, 1'b1, 4'd2, 32'h22222222, 4'h3, 32'h0, 1'b0, 1'b1);
        req(3, 1'b0, 4'd2, 32'h0, 4'h0, 32'h1111AAAA, 1'b0, 1'b0);
        tick();
        req(3, 1'b0, 4'd2, 32'h0, 4'h0, 32'h1111BBBB, 1'b0, 1'b0);
        tick();
        req(1, 1'b1, 4'd2, 32'h33333333, 4'h6, 32'h0, 1'b0, 1'b0);
        req(2, 1'b1, 4'd2, 32'h44444444, 4'hF, 32'h0, 1'b0, 1'b0);
        req(3, 1'b1, 4'd2, 32'h55555555, 4'h9, 32'h0, 1'b0, 1'b1);
        tick();
        req(2, 1'b0, 4'd2, 32'h0, 4'h0, 32'h44333344, 1'b0, 1'b0);
        tick();
        waitIdle(20);
    endtask

    task automatic test_read_during_write();
        req(0, 1'b1, 4'd5, 32'h9, 4'hF, 32'h0, 1'b0, 1'b0);
        tick();
        req(1, 1'b1, 4'd5, 32'h5, 4'hF, 32'h0, 1'b0, 1'b0);
        req(3, 1'b0, 4'd5, 32'h0, 4'h0, 32'h9, 1'b0, 1'b0);
        tick();
        req(3, 1'b0, 4'd5, 32'h0, 4'h0, 32'h5, 1'b0, 1'b0);
        tick();
        waitIdle(20);
    endtask

    task automatic test_out_of_bounds();
        req(0, 1'b0, 4'd13, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        req(1, 1'b1, 4'd13, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 1'b0);
        req(2, 1'b1, 4'd12, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 1'b0);
        req(3, 1'b0, 4'd11, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        req(0, 1'b0, 4'd5, 32'h0, 4'h0, 32'h5, 1'b0, 1'b0);
        req(1, 1'b0, 4'd1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        req(2, 1'b0, 4'd4, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        req(3, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        waitIdle(20);
    endtask

    task automatic test_back_to_back();
        logic [31:0] known [6];
        known = '{32'h0, 32'h0, 32'h44333344, 32'hDEADBEEF, 32'h0, 32'h5};
        for (int k = 0; k < 6; k++) begin
            req(0, 1'b0, 4'(k), 32'h0, 4'h0, known[k], 1'b0, 1'b0);
            req(3, 1'b1, 4'(6 + k), 32'h10000000 + 32'(k), 4'hF, 32'h0, 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            req(1, 1'b0, 4'(6 + k), 32'h0, 4'h0, 32'h10000000 + 32'(k), 1'b0, 1'b0);
            tick();
        end
        waitIdle(20);
    endtask

    task automatic test_reset_flush();
        for (int p = 0; p < NP; p++) setMain(p, 1'b1, 4'(6 + p), 32'h600D0006 + 32'(p), 4'hF);
        tick();
        for (int p = 0; p < NP; p++) setMain(p, 1'b0, 4'(p), 32'h0, 4'h0);
        tick();
        setMain(0, 1'b1, 4'd10, 32'h600D000A, 4'hF);
        setMain(1, 1'b1, 4'd11, 32'h600D000B, 4'hF);
        setMain(2, 1'b0, 4'd4, 32'h0, 4'h0);
        setMain(3, 1'b0, 4'd5, 32'h0, 4'h0);
        tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        testsRun++;
        if ({done, rdata, err, conf} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_main got done=%b err=%b conf=%b want all zero", done, err, conf);
        end
        setMain(0, 1'b1, 4'd6, 32'hBAD0BAD0, 4'hF);
        setMain(1, 1'b1, 4'd10, 32'hBAD0BAD0, 4'hF);
        repeat (3) @(negedge clk);
        clearInputs();
        reset = 1'b0;
        req(0, 1'b0, 4'd6, 32'h0, 4'h0, 32'h600D0006, 1'b0, 1'b0);
        req(1, 1'b0, 4'd10, 32'h0, 4'h0, 32'h600D000A, 1'b0, 1'b0);
        req(2, 1'b0, 4'd11, 32'h0, 4'h0, 32'h600D000B, 1'b0, 1'b0);
        req(3, 1'b0, 4'd9, 32'h0, 4'h0, 32'h600D0009, 1'b0, 1'b0);
        tick();
        waitIdle(20);
    endtask

    task automatic test_all_ports_stream();
        for (int p = 0; p < FNP; p++) fReq(p, 1'b1, 4'(p), pat(p), 32'h0);
        tick();
        for (int p = 0; p < FNP; p++) fReq(p, 1'b1, 4'(8 + p), pat(8 + p), 32'h0);
        tick();
        for (int k = 0; k < 20; k++) begin
            for (int p = 0; p < FNP; p++) fReq(p, 1'b0, 4'((p + k) % 16), 32'h0, pat((p + k) % 16));
            tick();
        end
        waitIdle(20);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_byte_merge();
        test_read_during_write();
        test_out_of_bounds();
        test_back_to_back();
        test_reset_flush();
        test_all_ports_stream();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
